// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network front end.
//   LFSR_WIDTH / LFSR_TAPS : geometry of the 16-bit Galois LFSR (right shift)
//   enc_state_t            : spike_rate_encoder FSM state encoding
//   lfsr_next()            : one Galois step, used by the LFSR register
package snn_pkg;

    localparam int          LFSR_WIDTH = 16;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_RUN  = 1'b1
    } enc_state_t;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Sample-in / spike-out bundle of the rate encoder.
//   pix_valid, pix_data : sample from the source
//   pix_ready           : encoder can take a sample
//   spike_out           : spike of the current timestep (valid only with step_valid)
//   step_valid          : one-cycle pulse per timestep
//   busy                : window in progress
//   done                : pulse on the last step_valid of a window
// Handshake: a sample transfers on every rising clk edge where pix_valid and
// pix_ready are both high; the source holds pix_data stable until then.
interface spike_rate_encoder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_ready;
    logic                  spike_out;
    logic                  step_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output pix_valid, pix_data,
        input  pix_ready, spike_out, step_valid, busy, done
    );

    modport slave (
        input  pix_valid, pix_data,
        output pix_ready, spike_out, step_valid, busy, done
    );
endinterface

// File: rtl/snn_lfsr16.sv
// 16-bit Galois LFSR register (taps 16'hB400, shift right).
//   clk, rst : clock, asynchronous active-high reset (loads the seed)
//   en       : advance one step on this edge
//   q        : current LFSR value
// An all-zero seed would lock the LFSR, so it is replaced by 16'h0001.
module snn_lfsr16
    import snn_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [LFSR_WIDTH-1:0] q
);
    localparam logic [LFSR_WIDTH-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= SEED_EFF;
        else if (en) q <= lfsr_next(q);
    end
endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: latches one intensity sample and emits NUM_STEPS timesteps,
// each spiking when the freshly advanced LFSR value is below the intensity.
//   clk, rst  : clock, asynchronous active-high reset
//   pix       : sample handshake and spike/step/done outputs (slave side)
//   state_dbg : current FSM state
//   lfsr_dbg  : current LFSR value
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          NUM_STEPS  = 16,
    parameter int          STEP_DIV   = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    spike_rate_encoder_if.slave   pix,
    output enc_state_t            state_dbg,
    output logic [LFSR_WIDTH-1:0] lfsr_dbg
);
    localparam int STEP_W = $clog2(NUM_STEPS + 1);
    localparam int DIV_W  = $clog2(STEP_DIV + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
    // Only the low DATA_WIDTH bits of the LFSR form the random number.
    localparam logic [LFSR_WIDTH-1:0] RND_MASK = LFSR_WIDTH'((32'd1 << DATA_WIDTH) - 32'd1);

    enc_state_t            state, next_state;
    logic [DIV_W-1:0]      div_cnt;
    logic [STEP_W-1:0]     step_cnt;
    logic [DATA_WIDTH-1:0] pix_data_q;
    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] rnd;
    logic                  accept, tick, last_tick, spike;
    logic                  ready_c, busy_c;
    logic                  step_valid_q, spike_q, done_q;

    assign accept    = pix.pix_valid && ready_c;
    assign tick      = (state == ENC_RUN) && (div_cnt == DIV_LAST);
    assign last_tick = tick && (step_cnt == STEP_LAST);

    // The spike decision looks at the value the LFSR takes on this tick.
    assign rnd   = lfsr_next(lfsr_q) & RND_MASK;
    assign spike = (pix_data_q == '1) ? 1'b1 : (rnd < LFSR_WIDTH'(pix_data_q));

    snn_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (tick),
        .q   (lfsr_q)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ENC_IDLE;
        else     state <= next_state;
    end

    // FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            ENC_IDLE: if (accept)    next_state = ENC_RUN;
            ENC_RUN:  if (last_tick) next_state = ENC_IDLE;
            default:                 next_state = ENC_IDLE;
        endcase
    end

    // FSM: outputs. Ready already returns in the done cycle, so the next
    // sample can follow without a bubble.
    always_comb begin
        ready_c = 1'b0;
        busy_c  = 1'b0;
        case (state)
            ENC_IDLE: ready_c = 1'b1;
            ENC_RUN:  busy_c  = 1'b1;
            default:  ready_c = 1'b1;
        endcase
    end

    // Sample latch, divider, step counter and registered step outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_data_q   <= '0;
            div_cnt      <= '0;
            step_cnt     <= '0;
            step_valid_q <= 1'b0;
            spike_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (accept) begin
                pix_data_q <= pix.pix_data;
                div_cnt    <= '0;
                step_cnt   <= '0;
            end else if (state == ENC_RUN) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick) step_cnt <= step_cnt + STEP_W'(1);
            end
            step_valid_q <= tick;
            spike_q      <= tick && spike;
            done_q       <= last_tick;
        end
    end

    assign pix.pix_ready  = ready_c;
    assign pix.busy       = busy_c;
    assign pix.step_valid = step_valid_q;
    assign pix.spike_out  = spike_q;
    assign pix.done       = done_q;
    assign state_dbg      = state;
    assign lfsr_dbg       = lfsr_q;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder. Three instances share clk/rst:
//   a: NUM_STEPS=16, STEP_DIV=1   b: NUM_STEPS=16, STEP_DIV=4
//   c: NUM_STEPS=1024, STEP_DIV=1
// Cycle index k=1 is the first cycle after the accepting clock edge.
module tb_spike_rate_encoder;
    import snn_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         dsel = 0;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_data = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr_a = 16'hACE1;
    logic [15:0] m_lfsr_b = 16'hACE1;
    logic [15:0] m_lfsr_c = 16'hACE1;

    int   p_cyc[$];
    logic p_spk[$];
    int   d_cyc[$];
    int   stray;

    always #5 clk = ~clk;

    spike_rate_encoder_if #(.DATA_WIDTH(8)) if_a ();
    spike_rate_encoder_if #(.DATA_WIDTH(8)) if_b ();
    spike_rate_encoder_if #(.DATA_WIDTH(8)) if_c ();

    assign if_a.pix_valid = drv_valid && (dsel == 0);
    assign if_b.pix_valid = drv_valid && (dsel == 1);
    assign if_c.pix_valid = drv_valid && (dsel == 2);
    assign if_a.pix_data  = drv_data;
    assign if_b.pix_data  = drv_data;
    assign if_c.pix_data  = drv_data;

    enc_state_t  st_a, st_b, st_c;
    logic [15:0] lf_a, lf_b, lf_c;

    spike_rate_encoder #(.DATA_WIDTH(8), .NUM_STEPS(16), .STEP_DIV(1), .LFSR_SEED(16'hACE1))
        dut_a (.clk(clk), .rst(rst), .pix(if_a), .state_dbg(st_a), .lfsr_dbg(lf_a));
    spike_rate_encoder #(.DATA_WIDTH(8), .NUM_STEPS(16), .STEP_DIV(4), .LFSR_SEED(16'hACE1))
        dut_b (.clk(clk), .rst(rst), .pix(if_b), .state_dbg(st_b), .lfsr_dbg(lf_b));
    spike_rate_encoder #(.DATA_WIDTH(8), .NUM_STEPS(1024), .STEP_DIV(1), .LFSR_SEED(16'hACE1))
        dut_spike_rate_c (.clk(clk), .rst(rst), .pix(if_c), .state_dbg(st_c), .lfsr_dbg(lf_c));

    logic o_ready, o_busy, o_step, o_spike, o_done;
    always_comb begin
        o_ready = if_a.pix_ready; o_busy = if_a.busy; o_step = if_a.step_valid;
        o_spike = if_a.spike_out; o_done = if_a.done;
        if (dsel == 1) begin
            o_ready = if_b.pix_ready; o_busy = if_b.busy; o_step = if_b.step_valid;
            o_spike = if_b.spike_out; o_done = if_b.done;
        end else if (dsel == 2) begin
            o_ready = if_c.pix_ready; o_busy = if_c.busy; o_step = if_c.step_valid;
            o_spike = if_c.spike_out; o_done = if_c.done;
        end
    end

    // Independent reference LFSR and spike rule.
    function automatic logic [15:0] m_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic exp_spike(input logic [7:0] d, input logic [15:0] l);
        logic [7:0] r;
        r = l[7:0];
        return (d == 8'hFF) ? 1'b1 : (r < d);
    endfunction

    // Offer one sample to the selected instance; returns at k=1.
    task automatic send(input logic [7:0] d, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        drv_valid = 1'b1;
        drv_data  = d;
        while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = o_ready;
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    task automatic capture(input int max_cyc);
        p_cyc.delete(); p_spk.delete(); d_cyc.delete(); stray = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (k > 1) @(negedge clk);
            if (o_step) begin
                p_cyc.push_back(k);
                p_spk.push_back(o_spike);
            end else if (o_spike || o_done) begin
                stray++;
            end
            if (o_done) d_cyc.push_back(k);
        end
    endtask

    // Advance the reference n ticks and count disagreements with p_spk[off+i].
    task automatic model_run(input logic [7:0] d, input int n, input int off,
                             inout logic [15:0] m, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            m = m_step(m);
            if (off + i < p_spk.size()) begin
                if (p_spk[off + i] !== exp_spike(d, m)) bad++;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_lfsr_a = 16'hACE1; m_lfsr_b = 16'hACE1; m_lfsr_c = 16'hACE1;
    endtask

    task automatic test_reset();
        bit ok;
        dsel = 0;
        send(8'hFF, ok);
        repeat (3) @(negedge clk);
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy: got %0b expected 1", o_busy); end
        n_cmp++; if (o_step !== 1'b1) begin n_bad++; $display("FAIL rst_pre_step: got %0b expected 1", o_step); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (o_step !== 1'b0) begin n_bad++; $display("FAIL rst_step_valid: got %0b expected 0", o_step); end
        n_cmp++; if (o_spike !== 1'b0) begin n_bad++; $display("FAIL rst_spike_out: got %0b expected 0", o_spike); end
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0b expected 0", o_done); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b expected 0", o_busy); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_pix_ready: got %0b expected 1", o_ready); end
        n_cmp++; if (lf_a !== 16'hACE1) begin n_bad++; $display("FAIL rst_lfsr: got %h expected ace1", lf_a); end
        n_cmp++; if (st_a !== ENC_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", st_a); end
        @(negedge clk);
        rst = 1'b0;
        m_lfsr_a = 16'hACE1; m_lfsr_b = 16'hACE1; m_lfsr_c = 16'hACE1;
    endtask

    task automatic test_zero_intensity();
        bit ok; int bad; int nsp;
        dsel = 0;
        send(8'h00, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL zero_accept: got 0 expected 1"); end
        capture(20);
        n_cmp++; if (p_cyc.size() != 16) begin n_bad++; $display("FAIL zero_pulses: got %0d expected 16", p_cyc.size()); end
        bad = 0;
        foreach (p_cyc[i]) if (p_cyc[i] != i + 2) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL zero_spacing: got %0d misplaced expected 0", bad); end
        nsp = 0;
        foreach (p_spk[i]) if (p_spk[i]) nsp++;
        n_cmp++; if (nsp != 0) begin n_bad++; $display("FAIL zero_spikes: got %0d expected 0", nsp); end
        n_cmp++; if (d_cyc.size() != 1 || d_cyc[0] != 17) begin
            n_bad++; $display("FAIL zero_done: got %0d pulses expected 1 at k=17", d_cyc.size()); end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL zero_stray: got %0d expected 0", stray); end
        model_run(8'h00, 16, 0, m_lfsr_a, bad);
        n_cmp++; if (lf_a !== m_lfsr_a) begin n_bad++; $display("FAIL zero_lfsr: got %h expected %h", lf_a, m_lfsr_a); end
    endtask

    task automatic test_full_scale();
        bit ok; int bad; int nsp;
        dsel = 0;
        send(8'hFF, ok);
        capture(20);
        nsp = 0;
        foreach (p_spk[i]) if (p_spk[i]) nsp++;
        n_cmp++; if (nsp != 16 || p_spk.size() != 16) begin
            n_bad++; $display("FAIL full_spikes: got %0d of %0d expected 16 of 16", nsp, p_spk.size()); end
        model_run(8'hFF, 16, 0, m_lfsr_a, bad);
        n_cmp++; if (lf_a !== m_lfsr_a) begin n_bad++; $display("FAIL full_lfsr: got %h expected %h", lf_a, m_lfsr_a); end
        // STEP_DIV=4 instance
        dsel = 1;
        send(8'hFF, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL div4_accept: got 0 expected 1"); end
        capture(70);
        bad = 0;
        foreach (p_cyc[i]) if (p_cyc[i] != 4 * i + 5) bad++;
        n_cmp++; if (bad != 0 || p_cyc.size() != 16) begin
            n_bad++; $display("FAIL div4_spacing: got %0d pulses, %0d misplaced expected 16, 0", p_cyc.size(), bad); end
        nsp = 0;
        foreach (p_spk[i]) if (p_spk[i]) nsp++;
        n_cmp++; if (nsp != 16) begin n_bad++; $display("FAIL div4_spikes: got %0d expected 16", nsp); end
        n_cmp++; if (d_cyc.size() != 1 || d_cyc[0] != 65) begin
            n_bad++; $display("FAIL div4_done: got %0d pulses expected 1 at k=65", d_cyc.size()); end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL div4_stray: got %0d expected 0", stray); end
        model_run(8'hFF, 16, 0, m_lfsr_b, bad);
        n_cmp++; if (lf_b !== m_lfsr_b || st_b !== ENC_IDLE) begin
            n_bad++; $display("FAIL div4_lfsr: got %h expected %h", lf_b, m_lfsr_b); end
    endtask

    task automatic test_long_window();
        bit ok; int bad; int nsp;
        dsel = 2;
        send(8'h80, ok);
        capture(1030);
        n_cmp++; if (p_cyc.size() != 1024) begin n_bad++; $display("FAIL long_pulses: got %0d expected 1024", p_cyc.size()); end
        model_run(8'h80, 1024, 0, m_lfsr_c, bad);
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL long_bitexact: got %0d wrong expected 0", bad); end
        nsp = 0;
        foreach (p_spk[i]) if (p_spk[i]) nsp++;
        n_cmp++; if (nsp < 448 || nsp > 576) begin n_bad++; $display("FAIL long_rate: got %0d expected 448..576", nsp); end
        n_cmp++; if (d_cyc.size() != 1 || d_cyc[0] != 1025) begin
            n_bad++; $display("FAIL long_done: got %0d pulses expected 1 at k=1025", d_cyc.size()); end
        n_cmp++; if (lf_c !== m_lfsr_c || st_c !== ENC_IDLE) begin
            n_bad++; $display("FAIL long_lfsr: got %h expected %h", lf_c, m_lfsr_c); end
    endtask

    task automatic test_back_to_back();
        int   acc_k[$];
        logic [7:0] acc_d[$];
        int   busy_acc; int bad; int exp_k;
        dsel = 0;
        p_cyc.delete(); p_spk.delete(); d_cyc.delete();
        busy_acc = 0;
        @(negedge clk);
        drv_valid = 1'b1;
        drv_data  = 8'h40;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            // The sample seen at the previous edge has already been taken.
            if (acc_k.size() == 1 && drv_data == 8'h40) drv_data = 8'hC0;
            if (acc_k.size() == 2) drv_valid = 1'b0;
            if (o_step) begin p_cyc.push_back(k); p_spk.push_back(o_spike); end
            if (o_done) d_cyc.push_back(k);
            if (drv_valid && o_ready) begin
                acc_k.push_back(k);
                acc_d.push_back(drv_data);
                if (o_busy) busy_acc++;
            end
        end
        n_cmp++; if (acc_k.size() != 2) begin n_bad++; $display("FAIL b2b_accepts: got %0d expected 2", acc_k.size()); end
        n_cmp++; if (acc_k.size() != 2 || d_cyc.size() == 0 || acc_k[1] != 17 || d_cyc[0] != 17) begin
            n_bad++; $display("FAIL b2b_in_done_cycle: got %0d accepts expected second at k=17 with done", acc_k.size()); end
        n_cmp++; if (acc_d.size() != 2 || acc_d[0] != 8'h40 || acc_d[1] != 8'hC0) begin
            n_bad++; $display("FAIL b2b_data: got %0d samples expected 40,c0", acc_d.size()); end
        n_cmp++; if (busy_acc != 0) begin n_bad++; $display("FAIL b2b_busy_accept: got %0d expected 0", busy_acc); end
        bad = 0;
        foreach (p_cyc[i]) begin
            exp_k = (i < 16) ? i + 2 : i + 3;
            if (p_cyc[i] != exp_k) bad++;
        end
        n_cmp++; if (bad != 0 || p_cyc.size() != 32) begin
            n_bad++; $display("FAIL b2b_pulses: got %0d pulses, %0d misplaced expected 32, 0", p_cyc.size(), bad); end
        n_cmp++; if (d_cyc.size() != 2 || d_cyc[1] != 34) begin
            n_bad++; $display("FAIL b2b_done: got %0d pulses expected 2 (k=17,34)", d_cyc.size()); end
        model_run(8'h40, 16, 0, m_lfsr_a, bad);
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL b2b_win1_bitexact: got %0d wrong expected 0", bad); end
        model_run(8'hC0, 16, 16, m_lfsr_a, bad);
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL b2b_win2_bitexact: got %0d wrong expected 0", bad); end
        n_cmp++; if (lf_a !== m_lfsr_a) begin n_bad++; $display("FAIL b2b_lfsr: got %h expected %h", lf_a, m_lfsr_a); end
    endtask

    task automatic test_reset_abort();
        bit ok; int bad; int npulse; int ndone; int extra;
        logic ref_spk[$];
        dsel = 0;
        pulse_reset();
        send(8'h5A, ok);
        capture(20);
        ref_spk = p_spk;
        model_run(8'h5A, 16, 0, m_lfsr_a, bad);
        n_cmp++; if (bad != 0 || p_spk.size() != 16) begin
            n_bad++; $display("FAIL abort_ref_bitexact: got %0d wrong of %0d expected 0 of 16", bad, p_spk.size()); end
        pulse_reset();
        send(8'h5A, ok);
        npulse = 0; ndone = 0;
        for (int k = 1; k <= 30 && npulse < 7; k++) begin
            if (k > 1) @(negedge clk);
            if (o_step) npulse++;
            if (o_done) ndone++;
        end
        n_cmp++; if (npulse != 7) begin n_bad++; $display("FAIL abort_reach_step7: got %0d expected 7", npulse); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (o_step !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1 || lf_a !== 16'hACE1) begin
            n_bad++; $display("FAIL abort_outputs: got step=%0b busy=%0b ready=%0b lfsr=%h expected 0 0 1 ace1",
                              o_step, o_busy, o_ready, lf_a); end
        @(negedge clk);
        rst = 1'b0;
        m_lfsr_a = 16'hACE1; m_lfsr_b = 16'hACE1; m_lfsr_c = 16'hACE1;
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_done) ndone++;
            if (o_step || o_busy) extra++;
        end
        n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles expected 0", extra); end
        send(8'h5A, ok);
        capture(20);
        bad = 0;
        foreach (p_spk[i]) if (i >= ref_spk.size() || p_spk[i] !== ref_spk[i]) bad++;
        n_cmp++; if (bad != 0 || p_spk.size() != 16) begin
            n_bad++; $display("FAIL abort_resend_train: got %0d differing of %0d expected 0 of 16", bad, p_spk.size()); end
        n_cmp++; if (d_cyc.size() != 1 || d_cyc[0] != 17) begin
            n_bad++; $display("FAIL abort_resend_done: got %0d pulses expected 1 at k=17", d_cyc.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_zero_intensity();
        test_full_scale();
        test_long_window();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
